// File: rtl/stm32_bus_interface.sv
// stm32_bus_interface: synchronous-parallel slave on the STM32 FMC/GPIO link.
// Define STM32_IF_CHECKSUM_EN to add the per-transfer XOR checksum beat.
module stm32_bus_interface #(
   parameter int BUS_W      = 4,
   parameter int IQ_W       = 16,
   parameter int FREQ_W     = 22,
   parameter int FREQ_RESET = 620407
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic [BUS_W-1:0]  data_in,
   input  logic              data_sync,
   input  logic [IQ_W-1:0]   rx_i,
   input  logic [IQ_W-1:0]   rx_q,
   input  logic              adc_otr,
   output logic [BUS_W-1:0]  data_out,
   output logic [FREQ_W-1:0] freq_out,
   output logic              preamp_enable,
   output logic              tx,
   output logic              rx,
   output logic [IQ_W-1:0]   tx_i,
   output logic [IQ_W-1:0]   tx_q,
   output logic              params_valid,
   output logic              tx_iq_valid,
   output logic              csum_error
);

   localparam int FREQ_BEATS = (FREQ_W + BUS_W - 1) / BUS_W;
   localparam int IQ2_W      = 2 * IQ_W;
   localparam int IQ_BEATS   = IQ2_W / BUS_W;
   localparam int CNT_W      = $clog2(IQ_BEATS + FREQ_BEATS + 2) + 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_GET  = 3'd1;
   localparam logic [2:0] S_SEND = 3'd2;
   localparam logic [2:0] S_TX   = 3'd3;
   localparam logic [2:0] S_RX   = 3'd4;

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [FREQ_W-1:0] fsh;
   logic [1:0]       flags_sh;
   logic [IQ2_W-1:0] iq_sh;
   logic [IQ2_W-1:0] rx_sh;
   logic             otr_sticky;
   logic [FREQ_W-1:0] fsh_nxt;
   logic [IQ2_W-1:0] iq_nxt;
   logic [BUS_W-1:0] rx_top;

   // Shadow shift paths: new beat enters at the LSB, stale MSBs fall off.
   assign fsh_nxt = FREQ_W'({fsh, data_in});
   assign iq_nxt  = IQ2_W'({iq_sh, data_in});
   assign rx_top  = rx_sh[IQ2_W-1 -: BUS_W];
   assign rx      = ~tx;

`ifdef STM32_IF_CHECKSUM_EN
   logic [BUS_W-1:0] csum;
   logic             csum_err_q;
   assign csum_error = csum_err_q;
`else
   assign csum_error = 1'b0;
`endif

   // Command decode, beat staging, atomic commit and readback.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         cnt           <= '0;
         fsh           <= '0;
         flags_sh      <= '0;
         iq_sh         <= '0;
         rx_sh         <= '0;
         otr_sticky    <= 1'b0;
         data_out      <= '0;
         freq_out      <= FREQ_W'(FREQ_RESET);
         preamp_enable <= 1'b0;
         tx            <= 1'b0;
         tx_i          <= '0;
         tx_q          <= '0;
         params_valid  <= 1'b0;
         tx_iq_valid   <= 1'b0;
`ifdef STM32_IF_CHECKSUM_EN
         csum          <= '0;
         csum_err_q    <= 1'b0;
`endif
      end else begin
         params_valid <= 1'b0;
         tx_iq_valid  <= 1'b0;
`ifdef STM32_IF_CHECKSUM_EN
         csum_err_q   <= 1'b0;
`endif
         if (adc_otr)
            otr_sticky <= 1'b1;
         if (data_sync) begin
            cnt      <= '0;
            fsh      <= '0;
            flags_sh <= '0;
            iq_sh    <= '0;
            rx_sh    <= {rx_q, rx_i};
`ifdef STM32_IF_CHECKSUM_EN
            csum     <= '0;
`endif
            unique case (data_in[3:0])
               4'd1:    state <= S_GET;
               4'd2:    state <= S_SEND;
               4'd3:    state <= S_TX;
               4'd4:    state <= S_RX;
               default: state <= S_IDLE;
            endcase
         end else begin
            unique case (state)
               S_GET: begin
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == '0)
                     flags_sh <= data_in[3:2];
                  else if (cnt <= CNT_W'(FREQ_BEATS))
                     fsh <= fsh_nxt;
`ifdef STM32_IF_CHECKSUM_EN
                  if (cnt <= CNT_W'(FREQ_BEATS))
                     csum <= csum ^ data_in;
                  if (cnt == CNT_W'(FREQ_BEATS + 1)) begin
                     state <= S_IDLE;
                     if (csum == data_in) begin
                        freq_out      <= fsh;
                        preamp_enable <= flags_sh[0];
                        tx            <= flags_sh[1];
                        params_valid  <= 1'b1;
                     end else begin
                        csum_err_q <= 1'b1;
                     end
                  end
`else
                  if (cnt == CNT_W'(FREQ_BEATS)) begin
                     state         <= S_IDLE;
                     freq_out      <= fsh_nxt;
                     preamp_enable <= flags_sh[0];
                     tx            <= flags_sh[1];
                     params_valid  <= 1'b1;
                  end
`endif
               end
               S_SEND: begin
                  data_out   <= BUS_W'({tx, otr_sticky});
                  otr_sticky <= adc_otr;
                  state      <= S_IDLE;
               end
               S_TX: begin
                  cnt <= cnt + CNT_W'(1);
`ifdef STM32_IF_CHECKSUM_EN
                  if (cnt < CNT_W'(IQ_BEATS)) begin
                     iq_sh <= iq_nxt;
                     csum  <= csum ^ data_in;
                  end else begin
                     state <= S_IDLE;
                     if (csum == data_in) begin
                        {tx_q, tx_i} <= iq_sh;
                        tx_iq_valid  <= 1'b1;
                     end else begin
                        csum_err_q <= 1'b1;
                     end
                  end
`else
                  iq_sh <= iq_nxt;
                  if (cnt == CNT_W'(IQ_BEATS - 1)) begin
                     state        <= S_IDLE;
                     {tx_q, tx_i} <= iq_nxt;
                     tx_iq_valid  <= 1'b1;
                  end
`endif
               end
               S_RX: begin
                  cnt <= cnt + CNT_W'(1);
`ifdef STM32_IF_CHECKSUM_EN
                  if (cnt < CNT_W'(IQ_BEATS)) begin
                     data_out <= rx_top;
                     rx_sh    <= rx_sh << BUS_W;
                     csum     <= csum ^ rx_top;
                  end else begin
                     data_out <= csum;
                     state    <= S_IDLE;
                  end
`else
                  data_out <= rx_top;
                  rx_sh    <= rx_sh << BUS_W;
                  if (cnt == CNT_W'(IQ_BEATS - 1))
                     state <= S_IDLE;
`endif
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_stm32_bus_interface.sv
// tb_stm32_bus_interface: directed scoreboard bench for stm32_bus_interface.
// Covers the checksum beat too when STM32_IF_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_stm32_bus_interface;

   localparam int BUS_W      = 4;
   localparam int IQ_W       = 16;
   localparam int FREQ_W     = 22;
   localparam int FREQ_RESET = 620407;
`ifdef STM32_IF_CHECKSUM_EN
   localparam int TX_BEATS = 9;
`else
   localparam int TX_BEATS = 8;
`endif

   logic              clk_in = 1'b0;
   logic              rst_n;
   logic [BUS_W-1:0]  data_in;
   logic              data_sync;
   logic [IQ_W-1:0]   rx_i;
   logic [IQ_W-1:0]   rx_q;
   logic              adc_otr;
   logic [BUS_W-1:0]  data_out;
   logic [FREQ_W-1:0] freq_out;
   logic              preamp_enable;
   logic              tx;
   logic              rx;
   logic [IQ_W-1:0]   tx_i;
   logic [IQ_W-1:0]   tx_q;
   logic              params_valid;
   logic              tx_iq_valid;
   logic              csum_error;

   stm32_bus_interface #(
      .BUS_W(BUS_W), .IQ_W(IQ_W), .FREQ_W(FREQ_W), .FREQ_RESET(FREQ_RESET)
   ) dut (
      .clk_in(clk_in), .rst_n(rst_n), .data_in(data_in),
      .data_sync(data_sync), .rx_i(rx_i), .rx_q(rx_q),
      .adc_otr(adc_otr), .data_out(data_out), .freq_out(freq_out),
      .preamp_enable(preamp_enable), .tx(tx), .rx(rx),
      .tx_i(tx_i), .tx_q(tx_q), .params_valid(params_valid),
      .tx_iq_valid(tx_iq_valid), .csum_error(csum_error)
   );

   always #5 clk_in = ~clk_in;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   int pv_cnt = 0;
   int tv_cnt = 0;
   int ce_cnt = 0;
   logic [31:0] sb[$];

   // Pulse counters: each high cycle is seen once at the closing edge.
   always @(posedge clk_in) begin
      if (params_valid) pv_cnt <= pv_cnt + 1;
      if (tx_iq_valid)  tv_cnt <= tv_cnt + 1;
      if (csum_error)   ce_cnt <= ce_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk = n_chk + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pop_chk(input string tag, input logic [31:0] obs);
      if (sb.size() == 0) begin
         n_chk  = n_chk + 1;
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %h expected <empty scoreboard>", tag, obs);
      end else begin
         chk(tag, obs, sb.pop_front());
      end
   endtask

   task automatic drive(input logic [3:0] d, input logic s);
      @(negedge clk_in);
      data_in   = d;
      data_sync = s;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(4'h0, 1'b0);
   endtask

   // TX_IQ transfer of word {q, i}, MSB-first; bad corrupts the checksum.
   task automatic send_iq(input logic [31:0] w, input logic bad);
      logic [3:0] cs;
      logic [3:0] nib;
      cs = 4'h0;
      drive(4'h3, 1'b1);
      for (int k = 0; k < 8; k++) begin
         nib = w[31-4*k -: 4];
         cs  = cs ^ nib;
         drive(nib, 1'b0);
      end
`ifdef STM32_IF_CHECKSUM_EN
      drive(bad ? ~cs : cs, 1'b0);
`else
      if (bad) cs = 4'h0;
`endif
   endtask

   task automatic send_par();
      drive(4'h2, 1'b1);
      drive(4'h0, 1'b0);
      drive(4'h0, 1'b0);
   endtask

   logic [3:0]  get_b [0:6];
   logic [21:0] exp_freq;
   logic [3:0]  cs;
   logic [3:0]  last;
   logic [31:0] rw;
   logic [15:0] cur_q;
   logic [15:0] cur_i;
   int          pv0;
   int          tv0;

   initial begin
      rst_n = 1'b0; data_in = '0; data_sync = 1'b0;
      rx_i = '0; rx_q = '0; adc_otr = 1'b0;
      repeat (3) @(negedge clk_in);
      rst_n = 1'b1;
      idle(10);
      chk("rst_freq", freq_out, FREQ_RESET);
      chk("rst_rx", rx, 1'b1);
      chk("rst_tx", tx, 1'b0);
      chk("rst_preamp", preamp_enable, 1'b0);
      chk("rst_data_out", data_out, 4'h0);
      chk("rst_pulses", {params_valid, tx_iq_valid, csum_error}, 3'b000);
      chk("rst_tx_iq", {tx_q, tx_i}, 32'h0);

      // GET_PARAMS: flags beat then six freq beats, MSB-first.
      get_b = '{4'hC, 4'h2, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
      exp_freq = '0;
      cs = 4'h0;
      for (int i = 1; i < 7; i++) exp_freq = {exp_freq[17:0], get_b[i]};
      sb.push_back(32'(exp_freq));
      pv0 = pv_cnt;
      drive(4'h1, 1'b1);
      for (int i = 0; i < 7; i++) begin
         cs = cs ^ get_b[i];
         drive(get_b[i], 1'b0);
      end
`ifdef STM32_IF_CHECKSUM_EN
      drive(cs, 1'b0);
`endif
      chk("get_pre_freq", freq_out, FREQ_RESET);
      chk("get_pre_tx", {tx, preamp_enable, params_valid}, 3'b000);
      drive(4'h0, 1'b0);
      pop_chk("get_freq", freq_out);
      chk("get_flags", {tx, rx, preamp_enable}, 3'b101);
      chk("get_pv_hi", params_valid, 1'b1);
      drive(4'h0, 1'b0);
      chk("get_pv_lo", params_valid, 1'b0);
      idle(2);
      chk("get_pv_once", pv_cnt - pv0, 1);

      // TX_IQ commit: Q=0x1234, I=0x8001 (negative).
      tv0 = tv_cnt;
      sb.push_back(32'h1234);
      sb.push_back(32'h8001);
      send_iq(32'h1234_8001, 1'b0);
      drive(4'h0, 1'b0);
      pop_chk("tx_q", tx_q);
      pop_chk("tx_i", tx_i);
      chk("tx_valid_hi", tx_iq_valid, 1'b1);
      drive(4'h0, 1'b0);
      chk("tx_valid_lo", tx_iq_valid, 1'b0);
      cur_q = 16'h1234;
      cur_i = 16'h8001;

      // Resync after 5 beats, then sync landing on the final beat.
      drive(4'h3, 1'b1);
      for (int k = 0; k < 5; k++) drive(4'(k + 5), 1'b0);
      drive(4'h3, 1'b1);
      for (int k = 0; k < TX_BEATS - 1; k++) drive(4'h9, 1'b0);
      drive(4'h0, 1'b1);
      idle(3);
      chk("abort_tx_iq", {tx_q, tx_i}, {cur_q, cur_i});
      chk("abort_no_pulse", tv_cnt - tv0, 1);

      // Fresh transfer after the aborts must carry only its own beats.
      sb.push_back(32'h0F0F_A5A5);
      send_iq(32'h0F0F_A5A5, 1'b0);
      idle(2);
      pop_chk("tx_after_abort", {tx_q, tx_i});
      cur_q = 16'h0F0F;
      cur_i = 16'hA5A5;

      // RX_IQ: snapshot at sync, inputs change right after.
      rx_q = 16'hFEDC;
      rx_i = 16'h0123;
      rw = {rx_q, rx_i};
      cs = 4'h0;
      for (int k = 0; k < 8; k++) begin
         last = rw[31-4*k -: 4];
         cs   = cs ^ last;
         sb.push_back(32'(last));
      end
`ifdef STM32_IF_CHECKSUM_EN
      sb.push_back(32'(cs));
      last = cs;
`endif
      drive(4'h4, 1'b1);
      drive(4'h0, 1'b0);
      rx_q = 16'h5555;
      rx_i = 16'hAAAA;
      for (int k = 0; k < TX_BEATS; k++) begin
         @(negedge clk_in);
         pop_chk("rx_beat", data_out);
      end
      idle(3);
      chk("rx_hold", data_out, last);

      // Sticky ADC overflow readback.
      @(negedge clk_in);
      adc_otr = 1'b1;
      @(negedge clk_in);
      adc_otr = 1'b0;
      send_par();
      chk("otr_first", data_out, 4'b0011);
      send_par();
      chk("otr_cleared", data_out, 4'b0010);
      adc_otr = 1'b1;
      send_par();
      chk("otr_held_1", data_out, 4'b0011);
      send_par();
      chk("otr_held_2", data_out, 4'b0011);
      adc_otr = 1'b0;

`ifdef STM32_IF_CHECKSUM_EN
      tv0 = tv_cnt;
      send_iq(32'h7777_1111, 1'b1);
      drive(4'h0, 1'b0);
      chk("csum_err_hi", csum_error, 1'b1);
      chk("csum_no_commit", {tx_q, tx_i}, {cur_q, cur_i});
      drive(4'h0, 1'b0);
      chk("csum_err_lo", csum_error, 1'b0);
      sb.push_back(32'h7777_1111);
      send_iq(32'h7777_1111, 1'b0);
      drive(4'h0, 1'b0);
      pop_chk("csum_commit", {tx_q, tx_i});
      idle(2);
      chk("csum_tv_once", tv_cnt - tv0, 1);
      chk("csum_err_once", ce_cnt, 1);
`else
      chk("csum_tied", {csum_error, 31'(ce_cnt)}, 32'h0);
`endif

      // Reset in the middle of a GET: staged beats must not commit later.
      pv0 = pv_cnt;
      drive(4'h1, 1'b1);
      drive(4'h8, 1'b0);
      drive(4'h1, 1'b0);
      drive(4'h2, 1'b0);
      @(negedge clk_in);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_freq", freq_out, FREQ_RESET);
      chk("mid_rst_flags", {tx, rx, preamp_enable}, 3'b010);
      chk("mid_rst_data", {data_out, tx_q, tx_i}, 36'h0);
      @(negedge clk_in);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) drive(4'h3, 1'b0);
      idle(3);
      chk("post_rst_freq", freq_out, FREQ_RESET);
      chk("post_rst_no_pv", pv_cnt - pv0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/stm32_bus_interface.md
# stm32_bus_interface

Parametrised successor to the nibble-wide STM32 link: a synchronous-parallel slave that the STM32 drives with a sync strobe plus command code, then clocks data beats in and out. It accepts tuning and mode parameters and TX IQ samples, and returns RX IQ samples and status. It generalises bus, sample and frequency widths. It also adds an atomic commit of multi-beat words, abort on re-sync, a sticky ADC-overflow flag and an optional per-transfer checksum. It sits between the STM32 FMC/GPIO pins and the DDC/DUC cores.

## Interface
- BUS_W, 4: data beat width; IQ_W must be a multiple of BUS_W.
- IQ_W, 16: signed I/Q sample width.
- FREQ_W, 22: NCO frequency word width; FREQ_BEATS = ceil(FREQ_W/BUS_W).
- FREQ_RESET, 620407: freq_out value after reset.
- clk_in  in  1  interface clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  BUS_W  beat from STM32; [3:0] carry the command code on sync.
- data_sync  in  1  high for one cycle = command cycle.
- rx_i, rx_q  in  IQ_W each  signed RX samples from DDC.
- adc_otr  in  1  ADC out-of-range.
- data_out  out  BUS_W  beat to STM32.
- freq_out  out  FREQ_W  NCO word.
- preamp_enable, tx, rx  out  1 each  mode flags; rx == !tx always.
- tx_i, tx_q  out  IQ_W each  signed TX samples to DUC.
- params_valid, tx_iq_valid  out  1 each  one-cycle commit pulses.
- csum_error  out  1  one-cycle pulse on checksum mismatch.

## Operation
- States: IDLE, GET_PARAMS, SEND_PARAMS, TX_IQ, RX_IQ; beat counter inside each state.
- data_sync=1 at any edge, in any state: the current transfer is aborted, nothing is committed and staged data is discarded. data_in[3:0] is decoded: 1→GET_PARAMS, 2→SEND_PARAMS, 3→TX_IQ, 4→RX_IQ, other→IDLE. The counter is zeroed.
- Each subsequent edge with data_sync=0 is one beat. There is no stall.
- GET_PARAMS: beat 0 gives preamp=data_in[2] and tx=data_in[3]. Beats 1..FREQ_BEATS carry freq MSB-first. Unused MSBs of the first freq beat are ignored. All values are staged in shadow registers. At the last beat, freq_out, preamp_enable, tx and rx update together and params_valid pulses. The block then returns to IDLE.
- SEND_PARAMS: on the first beat edge, data_out = {zeros, tx, otr_sticky}, with bit0=otr_sticky and bit1=tx. The block then returns to IDLE.
- otr_sticky: set at any edge with adc_otr=1. Cleared at the SEND_PARAMS report edge unless adc_otr=1 on that same edge (set wins).
- TX_IQ: 2·IQ_W/BUS_W beats, Q then I, each MSB-first. At the last beat, tx_i and tx_q update together and tx_iq_valid pulses.
- RX_IQ: rx_i and rx_q are snapshotted at the sync edge. Beat k (Q MSB-first, then I) is driven onto data_out at edge k+1 after sync.
- data_out holds its last value until the next SEND/RX beat.

## Timing
- Reset values: data_out=0, freq_out=FREQ_RESET, preamp_enable=0, tx=0, rx=1, tx_i=tx_q=0, all pulses=0, otr_sticky=0, state IDLE.
- Commit latency: outputs change at the edge that samples the last beat (or the checksum beat). The pulse is high for exactly the following cycle.
- RX latency: first beat is valid one cycle after the sync cycle, and new beats arrive every cycle.
- Reset asserted mid-transfer: immediate return to reset values; staged data is lost.
- Sync on the same edge as the final beat: sync wins and there is no commit.

## Configuration
- STM32_IF_CHECKSUM_EN defined:
  - GET_PARAMS and TX_IQ take one extra beat equal to the XOR of all payload beats, including GET flags beat 0.
  - On a match the block commits as normal.
  - On a mismatch it does not commit and pulses csum_error.
  - RX_IQ appends one output beat carrying the XOR of the beats it sent.
- Undefined: there is no extra beat and csum_error is tied 0.

## Test plan
- Reset, then idle 10 cycles → freq_out=620407, rx=1, tx=0, data_out=0, no pulses.
- Sync cmd 1, then beats C,2,A,B,C,D,E (defaults) → freq_out=0x2ABCDE, tx=1, rx=0, preamp=1. All change on one edge; params_valid pulses once.
- Sync cmd 3, beats 1,2,3,4,8,0,0,1 → tx_q=0x1234, tx_i=0x8001 (negative), tx_iq_valid pulses once. Resync with cmd 3 after 5 beats → no pulse, outputs unchanged.
- rx_q=0xFEDC, rx_i=0x0123 at sync cmd 4; change inputs afterwards → data_out=F,E,D,C,0,1,2,3 on cycles 1..8.
- Pulse adc_otr once, then two SEND_PARAMS → first data_out[0]=1, second 0. With adc_otr held high → both read 1.
- With STM32_IF_CHECKSUM_EN, TX_IQ with a wrong ninth beat → csum_error pulses, tx_i/tx_q unchanged. With the correct XOR beat → commit.
